// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard event queue: scancode
// constants, decoder states and the layout of a queued key event.
package kbd_pkg;

  // Prefix and modifier scancodes (set 2)
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_ALT     = 8'h11;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  // Keyboard status bytes that never form a key event
  localparam logic [7:0] SC_NONE    = 8'h00;
  localparam logic [7:0] SC_BAT_OK  = 8'hAA;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_RESEND  = 8'hFE;
  localparam logic [7:0] SC_ERROR   = 8'hFF;

  // Bytes still to swallow after the E1 that opens the pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BREAK  = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_LOOKUP = 3'd4,
    ST_PUSH   = 3'd5
  } kbd_state_e;

  // Entry bit positions
  localparam int unsigned BIT_BREAK = 15;
  localparam int unsigned BIT_EXT   = 14;
  localparam int unsigned BIT_SHIFT = 13;
  localparam int unsigned BIT_CTRL  = 12;
  localparam int unsigned BIT_ALT   = 11;
  localparam int unsigned BIT_CAPS  = 10;

  function automatic logic [15:0] make_entry(input logic       brk,
                                             input logic       ext,
                                             input logic       shift,
                                             input logic       ctrl,
                                             input logic       alt,
                                             input logic       caps,
                                             input logic [7:0] code);
    logic [15:0] e;
    e            = 16'h0000;
    e[BIT_BREAK] = brk;
    e[BIT_EXT]   = ext;
    e[BIT_SHIFT] = shift;
    e[BIT_CTRL]  = ctrl;
    e[BIT_ALT]   = alt;
    e[BIT_CAPS]  = caps;
    e[7:0]       = code;
    return e;
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Show-ahead FIFO: the head entry is presented on o_rdata while not empty
// (zero when empty). A write on a full FIFO is accepted only when a read
// frees the head slot in the same cycle.
module kbd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == {(AW+1){1'b0}});
  assign o_count = r_count;
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_rdata = o_empty ? {WIDTH{1'b0}} : r_mem[r_rptr];

  // Storage array; contents need no reset since occupancy gates the output
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 keyboard front end: decodes prefix/break/pause sequences, tracks
// modifiers, translates make codes via an external registered-address ROM
// and queues 16-bit key events for the CPU.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit REPORT_BREAK = 1'b0,
  parameter bit RAW_MODE     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_valid,
  input  logic [7:0]             scan_byte,
  output logic [9:0]             map_addr,
  input  logic [7:0]             map_data,
  output logic                   data_ready,
  output logic [15:0]            data_out,
  input  logic                   data_read,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   ovf_clear
);
  kbd_state_e  r_state, w_state_nxt;
  logic [7:0]  r_code, w_code_nxt;
  logic        r_brk, w_brk_nxt;
  logic        r_ext, w_ext_nxt;
  logic        r_lshift, w_lshift_nxt;
  logic        r_rshift, w_rshift_nxt;
  logic        r_ctrl, w_ctrl_nxt;
  logic        r_alt, w_alt_nxt;
  logic        r_caps, w_caps_nxt;
  logic        r_caps_held, w_caps_held_nxt;
  logic [2:0]  r_skip, w_skip_nxt;
  logic [9:0]  r_map_addr, w_map_addr_nxt;
  logic        r_overflow;
  logic        w_shift;
  logic        w_push;
  logic        w_pass_code;
  logic [7:0]  w_char;
  logic [15:0] w_entry;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;

  assign w_shift     = r_lshift | r_rshift;
  // Extended keys and raw mode report the scancode itself, never dropped
  assign w_pass_code = r_ext || RAW_MODE;
  assign w_char      = w_pass_code ? r_code : map_data;
  assign w_entry     = make_entry(r_brk, r_ext, w_shift, r_ctrl, r_alt, r_caps, w_char);
  assign w_drop      = w_push && w_full && !data_read;

  assign map_addr   = r_map_addr;
  assign overflow   = r_overflow;
  assign data_ready = !w_empty;

  // Decoder next-state, modifier updates and ROM address capture
  always_comb begin
    w_state_nxt     = r_state;
    w_code_nxt      = r_code;
    w_brk_nxt       = r_brk;
    w_ext_nxt       = r_ext;
    w_lshift_nxt    = r_lshift;
    w_rshift_nxt    = r_rshift;
    w_ctrl_nxt      = r_ctrl;
    w_alt_nxt       = r_alt;
    w_caps_nxt      = r_caps;
    w_caps_held_nxt = r_caps_held;
    w_skip_nxt      = r_skip;
    w_map_addr_nxt  = r_map_addr;
    w_push          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (scan_valid) begin
          case (scan_byte)
            SC_EXT:    begin w_state_nxt = ST_EXT;   w_ext_nxt = 1'b1; end
            SC_BREAK:  begin w_state_nxt = ST_BREAK; w_ext_nxt = 1'b0; end
            SC_PAUSE:  begin w_state_nxt = ST_PAUSE; w_skip_nxt = PAUSE_SKIP; end
            SC_NONE, SC_BAT_OK, SC_ACK, SC_RESEND, SC_ERROR: w_state_nxt = ST_IDLE;
            SC_LSHIFT: w_lshift_nxt = 1'b1;
            SC_RSHIFT: w_rshift_nxt = 1'b1;
            SC_CTRL:   w_ctrl_nxt   = 1'b1;
            SC_ALT:    w_alt_nxt    = 1'b1;
            SC_CAPS: begin
              // Held key repeats typematically; only the first make toggles
              if (!r_caps_held) w_caps_nxt = ~r_caps;
              else              w_caps_nxt = r_caps;
              w_caps_held_nxt = 1'b1;
            end
            default: begin
              w_state_nxt    = ST_LOOKUP;
              w_brk_nxt      = 1'b0;
              w_ext_nxt      = 1'b0;
              w_code_nxt     = scan_byte;
              w_map_addr_nxt = {r_caps, w_shift, scan_byte};
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXT: begin
        if (scan_valid) begin
          case (scan_byte)
            SC_BREAK:  w_state_nxt = ST_BREAK;
            SC_CTRL:   begin w_ctrl_nxt = 1'b1; w_state_nxt = ST_IDLE; end
            SC_ALT:    begin w_alt_nxt  = 1'b1; w_state_nxt = ST_IDLE; end
            SC_LSHIFT: w_state_nxt = ST_IDLE;  // fake shift around E0 keys
            default: begin
              w_state_nxt    = ST_LOOKUP;
              w_brk_nxt      = 1'b0;
              w_code_nxt     = scan_byte;
              w_map_addr_nxt = {r_caps, w_shift, scan_byte};
            end
          endcase
        end else begin
          w_state_nxt = ST_EXT;
        end
      end
      ST_BREAK: begin
        if (scan_valid) begin
          case (scan_byte)
            SC_LSHIFT: begin w_lshift_nxt    = 1'b0; w_state_nxt = ST_IDLE; end
            SC_RSHIFT: begin w_rshift_nxt    = 1'b0; w_state_nxt = ST_IDLE; end
            SC_CTRL:   begin w_ctrl_nxt      = 1'b0; w_state_nxt = ST_IDLE; end
            SC_ALT:    begin w_alt_nxt       = 1'b0; w_state_nxt = ST_IDLE; end
            SC_CAPS:   begin w_caps_held_nxt = 1'b0; w_state_nxt = ST_IDLE; end
            default: begin
              if (REPORT_BREAK) begin
                w_state_nxt    = ST_LOOKUP;
                w_brk_nxt      = 1'b1;
                w_code_nxt     = scan_byte;
                w_map_addr_nxt = {r_caps, w_shift, scan_byte};
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          endcase
        end else begin
          w_state_nxt = ST_BREAK;
        end
      end
      ST_PAUSE: begin
        if (scan_valid) begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1) w_state_nxt = ST_IDLE;
          else                w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_LOOKUP: w_state_nxt = ST_PUSH;
      ST_PUSH: begin
        // A zero from the ROM means "no character": drop the event
        if (w_pass_code || (map_data != 8'h00)) w_push = 1'b1;
        else                                    w_push = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decoder state, modifier and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_code      <= 8'h00;
      r_brk       <= 1'b0;
      r_ext       <= 1'b0;
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_ctrl      <= 1'b0;
      r_alt       <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_skip      <= 3'd0;
      r_map_addr  <= 10'h000;
    end else begin
      r_state     <= w_state_nxt;
      r_code      <= w_code_nxt;
      r_brk       <= w_brk_nxt;
      r_ext       <= w_ext_nxt;
      r_lshift    <= w_lshift_nxt;
      r_rshift    <= w_rshift_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_alt       <= w_alt_nxt;
      r_caps      <= w_caps_nxt;
      r_caps_held <= w_caps_held_nxt;
      r_skip      <= w_skip_nxt;
      r_map_addr  <= w_map_addr_nxt;
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  kbd_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_push),
    .i_wdata (w_entry),
    .i_rd    (data_read),
    .o_rdata (data_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

endmodule

// File: tb/tb_kbd_event_queue.sv
// Bench for kbd_event_queue: three configurations share one scancode stream
// and are compared every cycle against a byte-level reference model.
module tb_kbd_event_queue;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic       data_read = 1'b0;
  logic       ovf_clear = 1'b0;

  logic [9:0]  map_addr_w [3];
  logic [7:0]  map_data_r [3];
  logic        data_ready_w [3];
  logic [15:0] data_out_w [3];
  logic        overflow_w [3];
  logic [2:0]  cnt_a;
  logic [3:0]  cnt_b;
  logic [4:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;
  int rd_pct = 0;

  always #5 clk = ~clk;

  // A: DEPTH 4, presses only, ROM. B: DEPTH 8, releases too. C: DEPTH 16, raw.
  kbd_event_queue #(.DEPTH(4), .REPORT_BREAK(1'b0), .RAW_MODE(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .map_addr(map_addr_w[0]), .map_data(map_data_r[0]), .data_ready(data_ready_w[0]),
    .data_out(data_out_w[0]), .data_read(data_read), .fifo_count(cnt_a),
    .overflow(overflow_w[0]), .ovf_clear(ovf_clear));
  kbd_event_queue #(.DEPTH(8), .REPORT_BREAK(1'b1), .RAW_MODE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .map_addr(map_addr_w[1]), .map_data(map_data_r[1]), .data_ready(data_ready_w[1]),
    .data_out(data_out_w[1]), .data_read(data_read), .fifo_count(cnt_b),
    .overflow(overflow_w[1]), .ovf_clear(ovf_clear));
  kbd_event_queue #(.DEPTH(16), .REPORT_BREAK(1'b0), .RAW_MODE(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .map_addr(map_addr_w[2]), .map_data(map_data_r[2]), .data_ready(data_ready_w[2]),
    .data_out(data_out_w[2]), .data_read(data_read), .fifo_count(cnt_c),
    .overflow(overflow_w[2]), .ovf_clear(ovf_clear));

  // Scancode ROM contents: 1C maps to 'a'/'A', 0E and 70 are unmapped
  function automatic logic [7:0] rom_f(input logic [9:0] a);
    if (a[7:0] == 8'h1C) return (a[9] ^ a[8]) ? 8'h41 : 8'h61;
    if (a[7:0] == 8'h0E || a[7:0] == 8'h70) return 8'h00;
    return (a[7:0] + {a[9:8], 6'b000000}) | 8'h01;
  endfunction

  // Registered-address ROMs, one per instance
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) map_data_r[i] <= rom_f(map_addr_w[i]);
  end

  // ---------------- reference model ----------------
  int  m_depth [3];
  bit  m_rb [3];
  bit  m_raw [3];
  bit  m_lsh, m_rsh, m_ctrl, m_alt, m_caps, m_held, m_ext, m_brk;
  int  m_pause;
  logic [15:0] mq [3][16];
  int  mhead [3];
  int  mocc [3];
  bit  movf [3];
  logic [9:0] mmap [3];
  bit  pv [3];
  int  pc [3];
  logic [15:0] pe [3];

  task automatic model_reset();
    m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_held = 0;
    m_ext = 0; m_brk = 0; m_pause = 0;
    for (int i = 0; i < 3; i++) begin
      mhead[i] = 0; mocc[i] = 0; movf[i] = 0; mmap[i] = 10'h000; pv[i] = 0; pc[i] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit look, lbrk, lext;
    logic [9:0] addr;
    logic [7:0] ch;
    look = 0; lbrk = 0; lext = 0;
    if (m_pause > 0) begin
      m_pause--;
    end else if (m_brk) begin
      if      (b == 8'h12) m_lsh = 0;
      else if (b == 8'h59) m_rsh = 0;
      else if (b == 8'h14) m_ctrl = 0;
      else if (b == 8'h11) m_alt = 0;
      else if (b == 8'h58) m_held = 0;
      else begin look = 1; lbrk = 1; lext = m_ext; end
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        if      (b == 8'h14) m_ctrl = 1;
        else if (b == 8'h11) m_alt = 1;
        else if (b != 8'h12) begin look = 1; lext = 1; end
        m_ext = 0;
      end
    end else begin
      if      (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) look = 0;
      else if (b == 8'h12) m_lsh = 1;
      else if (b == 8'h59) m_rsh = 1;
      else if (b == 8'h14) m_ctrl = 1;
      else if (b == 8'h11) m_alt = 1;
      else if (b == 8'h58) begin
        if (!m_held) m_caps = !m_caps;
        m_held = 1;
      end else look = 1;
    end
    if (look) begin
      for (int i = 0; i < 3; i++) begin
        if (lbrk && !m_rb[i]) continue;
        addr = {m_caps, m_lsh | m_rsh, b};
        mmap[i] = addr;
        ch = (lext || m_raw[i]) ? b : rom_f(addr);
        if (!lext && !m_raw[i] && ch == 8'h00) continue;
        pv[i] = 1; pc[i] = 2;
        pe[i] = {lbrk, lext, m_lsh | m_rsh, m_ctrl, m_alt, m_caps, 2'b00, ch};
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs driven before it
  task automatic model_edge();
    bit rd_ok, wr, drop;
    for (int i = 0; i < 3; i++) begin
      rd_ok = data_read && (mocc[i] > 0);
      wr = 0;
      if (pv[i]) begin
        if (pc[i] == 1) begin wr = 1; pv[i] = 0; end
        else pc[i]--;
      end
      drop = wr && (mocc[i] == m_depth[i]) && !data_read;
      if (rd_ok) begin mhead[i] = (mhead[i] + 1) % 16; mocc[i]--; end
      if (wr && !drop) begin
        mq[i][(mhead[i] + mocc[i]) % 16] = pe[i];
        mocc[i]++;
      end
      if (drop) movf[i] = 1;
      else if (ovf_clear) movf[i] = 0;
    end
    if (scan_valid) model_byte(scan_byte);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, inst, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    if (i == 0) return {29'd0, cnt_a};
    if (i == 1) return {28'd0, cnt_b};
    return {27'd0, cnt_c};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("data_ready", i, {31'd0, data_ready_w[i]}, {31'd0, mocc[i] > 0});
      chk("data_out", i, {16'd0, data_out_w[i]}, {16'd0, (mocc[i] > 0) ? mq[i][mhead[i]] : 16'h0000});
      chk("fifo_count", i, cnt_of(i), mocc[i]);
      chk("overflow", i, {31'd0, overflow_w[i]}, {31'd0, movf[i]});
      chk("map_addr", i, {22'd0, map_addr_w[i]}, {22'd0, mmap[i]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // rdmode 0: no reads; 1: random reads/clears; 2: read only in the write cycle
  task automatic send_byte(input logic [7:0] b, input int gap, input int rdmode);
    for (int c = 0; c < gap; c++) begin
      scan_valid = (c == 0);
      scan_byte  = b;
      case (rdmode)
        0:       data_read = 1'b0;
        1:       data_read = ($urandom_range(0, 99) < rd_pct);
        default: data_read = (c == 2);
      endcase
      ovf_clear = (rdmode == 1) && ($urandom_range(0, 24) == 0);
      tick();
    end
    scan_valid = 1'b0; data_read = 1'b0; ovf_clear = 1'b0;
  endtask

  task automatic key(input logic [7:0] b);
    send_byte(b, 3, 0);
  endtask

  task automatic drain();
    data_read = 1'b1;
    repeat (17) tick();
    data_read = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] pool [18];
    pool = '{8'h1C, 8'h1C, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'hE0, 8'hF0,
             8'hF0, 8'hE1, 8'h75, 8'h0E, 8'hAA, 8'h00, 8'h70, 8'h2A, 8'h7D};
    return pool[$urandom_range(0, 17)];
  endfunction

  initial begin
    m_depth = '{4, 8, 16};
    m_rb    = '{1'b0, 1'b1, 1'b0};
    m_raw   = '{1'b0, 1'b0, 1'b1};
    model_reset();
    #12 check_all();
    rst_n = 1'b1;

    // Single make, then its release
    key(8'h1C);
    chk("t1_head", 0, {16'd0, data_out_w[0]}, 32'h0000_0061);
    chk("t1_raw_head", 2, {16'd0, data_out_w[2]}, 32'h0000_001C);
    drain();
    key(8'hF0); key(8'h1C);
    chk("t1_brk_count", 0, cnt_of(0), 32'd0);
    chk("t1_brk_head", 1, {16'd0, data_out_w[1]}, 32'h0000_8061);
    drain();

    // Shifted key with press and release
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
    chk("t2_head", 0, {16'd0, data_out_w[0]}, 32'h0000_2041);
    chk("t2_count", 1, cnt_of(1), 32'd2);
    data_read = 1'b1; tick(); data_read = 1'b0;
    chk("t2_release", 1, {16'd0, data_out_w[1]}, 32'h0000_A041);
    drain();

    // Caps lock with typematic repeat
    key(8'h58); key(8'h58); key(8'hF0); key(8'h58); key(8'h1C);
    chk("t3_map_addr", 0, {22'd0, map_addr_w[0]}, 32'h0000_021C);
    chk("t3_head", 0, {16'd0, data_out_w[0]}, 32'h0000_0441);
    key(8'h58); key(8'hF0); key(8'h58);
    drain();

    // Extended keys
    key(8'hE0); key(8'h75);
    chk("t4_ext", 0, {16'd0, data_out_w[0]}, 32'h0000_4075);
    drain();
    key(8'hE0); key(8'hF0); key(8'h75);
    chk("t4_ext_brk", 1, {16'd0, data_out_w[1]}, 32'h0000_C075);
    chk("t4_ext_brk_cnt", 0, cnt_of(0), 32'd0);
    drain();
    key(8'hE0); key(8'h12);
    chk("t4_fake_shift", 1, cnt_of(1), 32'd0);

    // Pause sequence, then a plain key must show no ctrl
    key(8'hE1); key(8'h14); key(8'h77); key(8'hE1);
    key(8'hF0); key(8'h14); key(8'hF0); key(8'h77);
    chk("t5_pause_cnt", 1, cnt_of(1), 32'd0);
    key(8'h1C);
    chk("t5_after_pause", 0, {16'd0, data_out_w[0]}, 32'h0000_0061);
    drain();
    key(8'h0E);
    chk("t5_rom_zero", 0, cnt_of(0), 32'd0);
    chk("t5_raw_zero", 2, {16'd0, data_out_w[2]}, 32'h0000_000E);
    drain();

    // Overflow on the 4-deep instance
    repeat (5) key(8'h1C);
    chk("t6_full_cnt", 0, cnt_of(0), 32'd4);
    chk("t6_ovf", 0, {31'd0, overflow_w[0]}, 32'd1);
    send_byte(8'h1C, 3, 2);
    chk("t6_rd_wr_full", 0, cnt_of(0), 32'd4);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("t6_ovf_clear", 0, {31'd0, overflow_w[0]}, 32'd0);
    drain();

    // Reset in the middle of an E0 sequence
    key(8'h1C);
    key(8'hE0);
    do_reset();
    key(8'h75);
    chk("t7_after_reset", 0, {16'd0, data_out_w[0]}, 32'h0000_0075);
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rd_pct = (n < 200) ? 25 : 70;
      send_byte(pick_byte(), $urandom_range(3, 5), 1);
      if ($urandom_range(0, 79) == 0) do_reset();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
